simple_fsm: RTL and testbench
=============================

# simple_fsm

Three-state Moore sequencer that cycles READY → SET → GO → READY, one state per clock, and drives a one-hot "get_*" indication of the current state. It is a self-contained control block with no data path. It is used standalone and in the chapter-9 FSM examples as the reference three-state controller. State types come from the shared package `fsm_types_pkg`.

## Interface

Parameters:
- None.

Package dependency:
- `fsm_types_pkg` must export `states_t`, an enum of type logic [1:0] with the following encoding:
  - READY = 2'b00
  - SET = 2'b01
  - GO = 2'b10
  - 2'b11 is unused.

Ports:
- clock  input  1  single system clock; all state updates occur on its rising edge.
- resetN  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- get_ready  output  1  high only while current_state == READY.
- get_set  output  1  high only while current_state == SET.
- get_going  output  1  high only while current_state == GO.

Required internal signals:
- `current_state` of type states_t: the state register. It must keep exactly this name, because hierarchical checks reference `dut.current_state`.
- `next_state` of type states_t: combinational next-state value.

## Operation

- Reset: on a rising clock edge with resetN == 0, current_state ← READY. Reset takes priority over any transition.
- Transitions, on a rising edge with resetN == 1:
  - READY → SET
  - SET → GO
  - GO → READY
  - The FSM advances unconditionally; there are no inputs other than clock and reset.
- Illegal encoding (2'b11): next_state = READY, giving recovery in one clock.
- Outputs are a pure Moore decode of current_state, from combinational logic only:
  - READY → {get_ready, get_set, get_going} = 3'b100
  - SET → 3'b010
  - GO → 3'b001
  - Illegal state → 3'b000
- At most one output is high at any time.
- Next-state logic is purely combinational with a default assignment, so no latches are inferred.

## Timing

- State register: a single flip-flop bank on posedge clock, with synchronous reset only. resetN must not appear in the sensitivity list.
- Output latency:
  - Outputs change only after a rising clock edge, from combinational decode of the new state; they are valid in the same cycle.
  - There is no output register.
- Reset timing:
  - If resetN is asserted, the first rising edge forces READY. Outputs read 3'b100 from that edge onward.
  - Before the first reset edge, state and outputs are undefined (X in simulation). Reset is mandatory.
- Reset release: the first rising edge with resetN == 1 moves READY → SET.
- Reset mid-operation: asserting resetN low in SET or GO returns to READY at the next rising edge, not immediately. Outputs hold their current value until that edge.
- Reset held low: the FSM stays in READY for every edge, and outputs remain 3'b100.
- Period: with continuous resetN == 1 the sequence repeats every 3 clocks, with the pattern 100, 010, 001, 100, …

## Test plan

Use a 10 ns clock and sample on falling edges.

1. Power-up reset: resetN = 0 through the first rising edge → current_state == READY and outputs 3'b100 at the next falling edge.
2. Sequence: release resetN before the second rising edge → successive falling-edge samples 010 (SET), 001 (GO), 100 (READY), 010 (SET). Each output must match the decode of current_state in every sample.
3. Mid-sequence reset: drive resetN low while in GO for one edge → READY / 100 after that edge. Release resetN → SET / 010 on the following edge.
4. Reset held: keep resetN low for 5 edges → READY / 100 at every sample, with no advancement.
5. Illegal-state recovery: force current_state = 2'b11 and release the force → outputs 3'b000 while illegal, then READY / 100 after one rising edge. Check that the outputs are one-hot or all-zero in every cycle of every scenario.

Source files
------------

// File: rtl/simple_fsm.sv
// Three-state Moore sequencer READY -> SET -> GO -> READY with one-hot get_* decode.
// Latency: state advances every clock edge; outputs are combinational from state. No flow control.

package fsm_types_pkg;
  typedef enum logic [1:0] {
    READY = 2'b00,
    SET   = 2'b01,
    GO    = 2'b10
  } states_t;
endpackage

module simple_fsm
  import fsm_types_pkg::*;
(
  input  logic clock,
  input  logic resetN,
  output logic get_ready,
  output logic get_set,
  output logic get_going
);

  states_t current_state;
  states_t next_state;

  always_ff @(posedge clock) begin
    if (!resetN) current_state <= READY;
    else         current_state <= next_state;
  end

  // The unused encoding 2'b11 falls into the default and recovers to READY.
  always_comb begin
    next_state = READY;
    case (current_state)
      READY:   next_state = SET;
      SET:     next_state = GO;
      GO:      next_state = READY;
      default: next_state = READY;
    endcase
  end

  always_comb begin
    get_ready = 1'b0;
    get_set   = 1'b0;
    get_going = 1'b0;
    case (current_state)
      READY:   get_ready = 1'b1;
      SET:     get_set   = 1'b1;
      GO:      get_going = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_simple_fsm.sv
// Scoreboard bench for simple_fsm: stimulus queues expected outputs/state, a monitor checks on falling edges.
`timescale 1ns/1ps

module tb_simple_fsm;
  import fsm_types_pkg::*;

  typedef struct {
    logic [2:0] outs;
    logic [1:0] st;
  } exp_t;

  logic clock;
  logic resetN;
  logic get_ready;
  logic get_set;
  logic get_going;

  int tests;
  int fails;
  exp_t exp_q[$];

  simple_fsm dut (
    .clock     (clock),
    .resetN    (resetN),
    .get_ready (get_ready),
    .get_set   (get_set),
    .get_going (get_going)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [1:0] st);
    exp_t e;
    e.st = st;
    case (st)
      2'b00:   e.outs = 3'b100;
      2'b01:   e.outs = 3'b010;
      2'b10:   e.outs = 3'b001;
      default: e.outs = 3'b000;
    endcase
    return e;
  endfunction

  // Monitor: every falling edge with a pending expectation is checked.
  initial begin
    exp_t e;
    logic [2:0] act;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {get_ready, get_set, get_going};
        tests++;
        if (act !== e.outs) begin
          fails++;
          $display("FAIL outputs: got %b expected %b at %0t", act, e.outs, $time);
        end
        tests++;
        if (dut.current_state !== e.st) begin
          fails++;
          $display("FAIL state: got %b expected %b at %0t", dut.current_state, e.st, $time);
        end
        tests++;
        if ($countones(act) > 1 || $isunknown(act)) begin
          fails++;
          $display("FAIL onehot: got %b expected at most one bit set at %0t", act, $time);
        end
      end
    end
  end

  task automatic step(input logic rst_n, input logic [1:0] exp_st);
    resetN = rst_n;
    exp_q.push_back(mk(exp_st));
    @(negedge clock);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up reset through the first rising edge
    step(1'b0, 2'b00);
    // Free-running sequence
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    step(1'b1, 2'b00);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    // Reset while in GO, then release
    step(1'b0, 2'b00);
    step(1'b1, 2'b01);
    // Reset while in SET
    step(1'b0, 2'b00);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    // Reset held for five edges
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    step(1'b1, 2'b00);
    // Illegal encoding held across an edge, then released
    resetN = 1'b1;
    force dut.current_state = states_t'(2'b11);
    exp_q.push_back(mk(2'b11));
    @(negedge clock);
    #2;
    release dut.current_state;
    step(1'b1, 2'b00);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    // Reset takes priority over recovery from the illegal encoding
    force dut.current_state = states_t'(2'b11);
    exp_q.push_back(mk(2'b11));
    @(negedge clock);
    #2;
    release dut.current_state;
    step(1'b0, 2'b00);
    step(1'b1, 2'b01);

    @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
